// File: rtl/k423_pcu_sb_if.sv
// k423 scoreboard PCU bus: ID decode/issue, MDU completion, WB branch in;
// stall/flush and perf counters out.
interface k423_pcu_sb_if #(
  parameter int NUM_RS = 2,
  parameter int IDX_W  = 5
);
  logic [NUM_RS-1:0]       id_dec_rs_vld_i;
  logic [NUM_RS*IDX_W-1:0] id_dec_rs_idx_i;
  logic                    id_dec_rd_vld_i;
  logic [IDX_W-1:0]        id_dec_rd_idx_i;
  logic                    id_dec_load_i;
  logic                    id_dec_mdu_i;
  logic                    id_issue_i;
  logic                    mdu_done_i;
  logic [IDX_W-1:0]        mdu_done_idx_i;
  logic                    wb_bju_br_tkn_i;
  logic                    pcu_stall_o;
  logic                    pcu_flush_o;
  logic [31:0]             pcu_perf_stall_cnt_o;
  logic [31:0]             pcu_perf_flush_cnt_o;

  modport master (
    output id_dec_rs_vld_i, id_dec_rs_idx_i,
    output id_dec_rd_vld_i, id_dec_rd_idx_i,
    output id_dec_load_i, id_dec_mdu_i,
    output id_issue_i, mdu_done_i,
    output mdu_done_idx_i, wb_bju_br_tkn_i,
    input  pcu_stall_o, pcu_flush_o,
    input  pcu_perf_stall_cnt_o,
    input  pcu_perf_flush_cnt_o
  );

  modport slave (
    input  id_dec_rs_vld_i, id_dec_rs_idx_i,
    input  id_dec_rd_vld_i, id_dec_rd_idx_i,
    input  id_dec_load_i, id_dec_mdu_i,
    input  id_issue_i, mdu_done_i,
    input  mdu_done_idx_i, wb_bju_br_tkn_i,
    output pcu_stall_o, pcu_flush_o,
    output pcu_perf_stall_cnt_o,
    output pcu_perf_flush_cnt_o
  );
endinterface

// File: rtl/k423_pcu_sb.sv
// k423 scoreboard PCU: load countdown + MDU busy bits drive stall/flush.
// Optional perf counters enabled by defining K423_PCU_PERF_EN.
module k423_pcu_sb #(
  parameter int NUM_RS   = 2,
  parameter int IDX_W    = 5,
  parameter int LOAD_LAT = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  k423_pcu_sb_if.slave  bus
);
  localparam int NR = 2**IDX_W;
  localparam int CW = $clog2(LOAD_LAT+1);
  localparam logic [CW-1:0] LAT = CW'(LOAD_LAT);

  logic [CW-1:0] r_cnt [NR];
  logic [NR-1:0] r_busy;

  logic [NR-1:0] w_pend;
  logic          w_raw;
  logic          w_waw;
  logic          w_strc;
  logic          w_flush;
  logic          w_stall;
  logic          w_acc;
  logic          w_ld_set;
  logic          w_md_set;
  logic [IDX_W-1:0] w_rs;

  always_comb begin
    for (int r = 0; r < NR; r++) begin
      w_pend[r] = (r_cnt[r] != '0) | r_busy[r];
    end
  end

  always_comb begin
    w_raw = 1'b0;
    w_rs  = '0;
    for (int k = 0; k < NUM_RS; k++) begin
      w_rs  = bus.id_dec_rs_idx_i[k*IDX_W +: IDX_W];
      w_raw = w_raw |
              (bus.id_dec_rs_vld_i[k] &
               (w_rs != '0) & w_pend[w_rs]);
    end
  end

  assign w_waw = bus.id_dec_rd_vld_i &
                 (bus.id_dec_rd_idx_i != '0) &
                 w_pend[bus.id_dec_rd_idx_i];
  assign w_strc = bus.id_dec_mdu_i & (|r_busy);

  assign w_flush = bus.wb_bju_br_tkn_i & ~rst_i;
  assign w_stall = ~w_flush & ~rst_i &
                   (w_raw | w_waw | w_strc);
  assign w_acc   = bus.id_issue_i & ~w_stall & ~w_flush;

  // load wins over mdu if both are flagged
  assign w_ld_set = w_acc & bus.id_dec_rd_vld_i &
                    bus.id_dec_load_i;
  assign w_md_set = w_acc & bus.id_dec_rd_vld_i &
                    bus.id_dec_mdu_i & ~bus.id_dec_load_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < NR; r++) begin
        r_cnt[r] <= '0;
      end
      r_busy <= '0;
    end else begin
      for (int r = 0; r < NR; r++) begin
        if (r == 0 || w_flush) begin
          r_cnt[r]  <= '0;
          r_busy[r] <= 1'b0;
        end else begin
          if (w_ld_set &&
              bus.id_dec_rd_idx_i == IDX_W'(r))
            r_cnt[r] <= LAT;
          else if (r_cnt[r] != '0)
            r_cnt[r] <= r_cnt[r] - 1'b1;
          if (w_md_set &&
              bus.id_dec_rd_idx_i == IDX_W'(r))
            r_busy[r] <= 1'b1;
          else if (bus.mdu_done_i &&
                   bus.mdu_done_idx_i == IDX_W'(r))
            r_busy[r] <= 1'b0;
        end
      end
    end
  end

  assign bus.pcu_stall_o = w_stall;
  assign bus.pcu_flush_o = w_flush;

`ifdef K423_PCU_PERF_EN
  logic [31:0] r_pstall;
  logic [31:0] r_pflush;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pstall <= '0;
      r_pflush <= '0;
    end else begin
      if (w_stall) r_pstall <= r_pstall + 32'd1;
      if (w_flush) r_pflush <= r_pflush + 32'd1;
    end
  end

  assign bus.pcu_perf_stall_cnt_o = r_pstall;
  assign bus.pcu_perf_flush_cnt_o = r_pflush;
`else
  assign bus.pcu_perf_stall_cnt_o = 32'd0;
  assign bus.pcu_perf_flush_cnt_o = 32'd0;
`endif
endmodule

// File: tb/tb_k423_pcu_sb.sv
// Scoreboard bench for k423_pcu_sb: per-cycle expected stall/flush
// queued by the stimulus and checked by a negedge monitor.
module tb_k423_pcu_sb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  k423_pcu_sb_if #(.NUM_RS(2), .IDX_W(5)) bus_if ();

  k423_pcu_sb #(
    .NUM_RS(2), .IDX_W(5), .LOAD_LAT(2)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if)
  );

  typedef struct {
    string name;
    logic  stall;
    logic  flush;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int es = 0;
  int ef = 0;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_tests++;
      if (bus_if.pcu_stall_o !== e.stall ||
          bus_if.pcu_flush_o !== e.flush) begin
        n_fail++;
        $display("FAIL %s: stall=%0b flush=%0b, expected stall=%0b flush=%0b",
                 e.name, bus_if.pcu_stall_o, bus_if.pcu_flush_o,
                 e.stall, e.flush);
      end
    end
  end

  task automatic idle();
    bus_if.id_dec_rs_vld_i = '0;
    bus_if.id_dec_rs_idx_i = '0;
    bus_if.id_dec_rd_vld_i = 1'b0;
    bus_if.id_dec_rd_idx_i = '0;
    bus_if.id_dec_load_i   = 1'b0;
    bus_if.id_dec_mdu_i    = 1'b0;
    bus_if.id_issue_i      = 1'b0;
    bus_if.mdu_done_i      = 1'b0;
    bus_if.mdu_done_idx_i  = '0;
    bus_if.wb_bju_br_tkn_i = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic src(input int k, input int idx);
    bus_if.id_dec_rs_vld_i[k] = 1'b1;
    bus_if.id_dec_rs_idx_i[k*5 +: 5] = 5'(idx);
    bus_if.id_issue_i = 1'b1;
  endtask

  task automatic dst(input int idx, input logic ld,
                     input logic md);
    bus_if.id_dec_rd_vld_i = 1'b1;
    bus_if.id_dec_rd_idx_i = 5'(idx);
    bus_if.id_dec_load_i   = ld;
    bus_if.id_dec_mdu_i    = md;
    bus_if.id_issue_i      = 1'b1;
  endtask

  task automatic done(input int idx);
    bus_if.mdu_done_i     = 1'b1;
    bus_if.mdu_done_idx_i = 5'(idx);
  endtask

  task automatic expect_o(input string n, input logic s,
                          input logic f);
    exp_t e;
    e.name  = n;
    e.stall = s;
    e.flush = f;
    q.push_back(e);
    if (s) es++;
    if (f) ef++;
  endtask

  initial begin
    logic [31:0] xs;
    logic [31:0] xf;
    idle();
    // reset masks flush
    cyc(); rst = 1'b1; bus_if.wb_bju_br_tkn_i = 1'b1;
    expect_o("rst_flush_masked", 1'b0, 1'b0);
    cyc(); rst = 1'b0; expect_o("post_rst", 1'b0, 1'b0);

    // load x5, consumer waits LOAD_LAT cycles
    cyc(); dst(5, 1, 0); expect_o("ld5_iss", 0, 0);
    cyc(); src(0, 5); expect_o("ld5_use_c1", 1, 0);
    cyc(); src(0, 5); expect_o("ld5_use_c2", 1, 0);
    cyc(); src(0, 5); expect_o("ld5_use_c3", 0, 0);

    // x0 never tracked
    cyc(); dst(0, 1, 0); expect_o("ld0_iss", 0, 0);
    cyc(); src(1, 0); expect_o("ld0_use", 0, 0);

    // WAW on pending load, stray mdu_done is a no-op
    cyc(); dst(6, 1, 0); expect_o("ld6_iss", 0, 0);
    cyc(); dst(6, 0, 0); done(12); expect_o("waw6", 1, 0);
    cyc(); dst(6, 0, 0); expect_o("waw6_c2", 1, 0);
    cyc(); dst(6, 0, 0); expect_o("waw6_go", 0, 0);

    // MDU x7 with RAW and structural stalls
    cyc(); dst(7, 0, 1); expect_o("mdu7_iss", 0, 0);
    cyc(); src(0, 7); expect_o("mdu7_raw", 1, 0);
    cyc(); dst(9, 0, 1); expect_o("mdu9_strc", 1, 0);
    cyc(); dst(9, 0, 1); done(7); expect_o("mdu9_strc_done", 1, 0);
    cyc(); dst(9, 0, 1); expect_o("mdu9_iss", 0, 0);
    cyc(); src(0, 7); expect_o("mdu7_use", 0, 0);
    cyc(); src(1, 9); expect_o("mdu9_raw", 1, 0);
    cyc(); done(9); expect_o("mdu9_done", 0, 0);
    cyc(); src(1, 9); expect_o("mdu9_use", 0, 0);

    // flush overrides stall and clears countdown
    cyc(); dst(3, 1, 0); expect_o("ld3_iss", 0, 0);
    cyc(); src(0, 3); bus_if.wb_bju_br_tkn_i = 1'b1;
    expect_o("br_flush", 0, 1);
    cyc(); src(0, 3); expect_o("ld3_after_flush", 0, 0);

    // set wins over same-cycle done
    cyc(); dst(4, 0, 1); done(4); expect_o("mdu4_set_done", 0, 0);
    cyc(); src(0, 4); expect_o("mdu4_busy", 1, 0);
    cyc(); done(4); expect_o("mdu4_done", 0, 0);
    cyc(); src(0, 4); expect_o("mdu4_use", 0, 0);

    // async reset mid-countdown
    cyc(); dst(8, 1, 0); expect_o("ld8_iss", 0, 0);
    cyc(); src(0, 8); expect_o("ld8_raw", 1, 0);
    cyc(); rst = 1'b1; src(0, 8); es = 0; ef = 0;
    expect_o("rst_mid", 0, 0);
    cyc(); rst = 1'b0; src(0, 8); expect_o("ld8_after_rst", 0, 0);

    // perf window: 3 stalls, 1 flush since reset
    cyc(); dst(10, 1, 0); expect_o("ld10_iss", 0, 0);
    cyc(); src(0, 10); expect_o("ld10_c1", 1, 0);
    cyc(); src(0, 10); expect_o("ld10_c2", 1, 0);
    cyc(); src(0, 10); dst(11, 1, 0); expect_o("ld11_iss", 0, 0);
    cyc(); dst(11, 0, 0); expect_o("waw11", 1, 0);
    cyc(); dst(11, 0, 0); bus_if.wb_bju_br_tkn_i = 1'b1;
    expect_o("br_flush2", 0, 1);
    cyc(); src(0, 11); expect_o("ld11_after_flush", 0, 0);
    cyc(); expect_o("idle_end", 0, 0);

    for (int i = 0; i < 8 && q.size() != 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end

`ifdef K423_PCU_PERF_EN
    xs = 32'(es);
    xf = 32'(ef);
`else
    xs = 32'd0;
    xf = 32'd0;
`endif
    n_tests++;
    if (bus_if.pcu_perf_stall_cnt_o !== xs) begin
      n_fail++;
      $display("FAIL perf_stall: got %0d, expected %0d",
               bus_if.pcu_perf_stall_cnt_o, xs);
    end
    n_tests++;
    if (bus_if.pcu_perf_flush_cnt_o !== xf) begin
      n_fail++;
      $display("FAIL perf_flush: got %0d, expected %0d",
               bus_if.pcu_perf_flush_cnt_o, xf);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
